// File: rtl/cut_test_sequencer.sv
// cut_test_sequencer
// Drives the eight input vectors {A,B,C} = 000..111 into the lab circuit
// x = (A|B)&~C, y = ~C. Each vector is held for SETTLE cycles so the gate
// delays can resolve. The returned {x,y} is then sampled once and compared
// against the expected function, and the mismatches of the sweep are counted.

module cut_test_sequencer #(
    parameter int unsigned SETTLE = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    output logic [2:0] cut_in,
    input  logic [1:0] cut_out,
    output logic       sample_valid,
    output logic [2:0] sample_vec,
    output logic [1:0] sample_obs,
    output logic       mismatch,
    output logic [3:0] err_cnt,
    output logic       busy,
    output logic       done
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_APPLY  = 3'd1;
    localparam logic [2:0] ST_SETTLE = 3'd2;
    localparam logic [2:0] ST_SAMPLE = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    // The counter is loaded with SETTLE-1 and stops on zero, so the FSM
    // stays exactly SETTLE cycles in SETTLE.
    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE - 1);

    // Expected response of a fault-free circuit: {x, y}.
    function automatic logic [1:0] exp_fn(input logic [2:0] v);
        logic a_s;
        logic b_s;
        logic c_s;
        a_s = v[2];
        b_s = v[1];
        c_s = v[0];
        return {(a_s | b_s) & ~c_s, ~c_s};
    endfunction

    logic [2:0] state_q,        state_d;
    logic [2:0] vec_q,          vec_d;
    logic [7:0] cnt_q,          cnt_d;
    logic [2:0] cut_in_q,       cut_in_d;
    logic       sample_valid_q, sample_valid_d;
    logic [2:0] sample_vec_q,   sample_vec_d;
    logic [1:0] sample_obs_q,   sample_obs_d;
    logic       mismatch_q,     mismatch_d;
    logic [3:0] err_cnt_q,      err_cnt_d;
    logic       mis_s;

    // Next-state logic for the sweep FSM and all output registers.
    always_comb begin
        mis_s          = (cut_out != exp_fn(vec_q));
        state_d        = state_q;
        vec_d          = vec_q;
        cnt_d          = cnt_q;
        cut_in_d       = cut_in_q;
        sample_valid_d = 1'b0;
        sample_vec_d   = sample_vec_q;
        sample_obs_d   = sample_obs_q;
        mismatch_d     = mismatch_q;
        err_cnt_d      = err_cnt_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                // abort wins over start here, so no sweep begins.
                if (start && !abort) begin
                    state_d   = ST_APPLY;
                    vec_d     = 3'd0;
                    err_cnt_d = 4'd0;
                end else begin
                    state_d   = state_q;
                end
            end
            ST_APPLY: begin
                if (abort) begin
                    state_d  = ST_IDLE;
                    cut_in_d = 3'd0;
                end else begin
                    cut_in_d = vec_q;
                    cnt_d    = SETTLE_LOAD;
                    state_d  = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (abort) begin
                    state_d  = ST_IDLE;
                    cut_in_d = 3'd0;
                end else if (cnt_q == 8'd0) begin
                    state_d  = ST_SAMPLE;
                end else begin
                    cnt_d    = cnt_q - 8'd1;
                end
            end
            ST_SAMPLE: begin
                if (abort) begin
                    state_d  = ST_IDLE;
                    cut_in_d = 3'd0;
                end else begin
                    sample_valid_d = 1'b1;
                    sample_vec_d   = vec_q;
                    sample_obs_d   = cut_out;
                    mismatch_d     = mis_s;
                    // At most eight samples per sweep, so four bits never wrap.
                    err_cnt_d      = err_cnt_q + {3'b000, mis_s};
                    if (vec_q == 3'd7) begin
                        state_d = ST_DONE;
                    end else begin
                        vec_d   = vec_q + 3'd1;
                        state_d = ST_APPLY;
                    end
                end
            end
            default: begin
                state_d  = ST_IDLE;
                cut_in_d = 3'd0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            vec_q          <= 3'd0;
            cnt_q          <= 8'd0;
            cut_in_q       <= 3'd0;
            sample_valid_q <= 1'b0;
            sample_vec_q   <= 3'd0;
            sample_obs_q   <= 2'd0;
            mismatch_q     <= 1'b0;
            err_cnt_q      <= 4'd0;
        end else begin
            state_q        <= state_d;
            vec_q          <= vec_d;
            cnt_q          <= cnt_d;
            cut_in_q       <= cut_in_d;
            sample_valid_q <= sample_valid_d;
            sample_vec_q   <= sample_vec_d;
            sample_obs_q   <= sample_obs_d;
            mismatch_q     <= mismatch_d;
            err_cnt_q      <= err_cnt_d;
        end
    end

    assign cut_in       = cut_in_q;
    assign sample_valid = sample_valid_q;
    assign sample_vec   = sample_vec_q;
    assign sample_obs   = sample_obs_q;
    assign mismatch     = mismatch_q;
    assign err_cnt      = err_cnt_q;
    assign busy         = (state_q == ST_APPLY) || (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
    assign done         = (state_q == ST_DONE);

endmodule
